// File: rtl/torrence_params.sv
// Shared memory-port types and the arbitration mode selector.
package torrence_params;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } mem_op_e;

    typedef enum logic {
        ARB_ROUND_ROBIN    = 1'b0,
        ARB_FIXED_PRIORITY = 1'b1
    } arb_mode_e;

    // Increment with wrap at n, valid for any n (not only powers of two).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/memory_if.sv
// Simple request/fulfil memory port between a requester and a server.
interface memory_if
    import torrence_params::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic            req_valid;
    logic [XLEN-1:0] address;
    mem_op_e         operation;
    logic [XLEN-1:0] store_word;
    logic            req_fulfilled;
    logic [XLEN-1:0] req_loaded_word;

    modport requester (
        output req_valid, address, operation, store_word,
        input  req_fulfilled, req_loaded_word
    );

    modport server (
        input  req_valid, address, operation, store_word,
        output req_fulfilled, req_loaded_word
    );

endinterface

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational picker: first valid index scanning start, start+1, ... modulo N.
module rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [IdxW-1:0] start_i,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    int unsigned cand;

    always_comb begin
        idx_o = '0;
        any_o = |valid_i;
        cand  = 0;
        // Scan from the far end back so the closest valid index to start_i wins.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            cand = int'(start_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (valid_i[cand[IdxW-1:0]]) begin
                idx_o = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_REQ upstream memory ports onto one downstream port, holding
// ownership until the request is fulfilled or the owner withdraws it.
module mem_req_arbiter
    import torrence_params::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REQ  = 2,
    parameter arb_mode_e   ARB_MODE = ARB_ROUND_ROBIN
) (
    input  logic                       clk,
    input  logic                       reset,
    memory_if.server                   req_if [NUM_REQ],
    memory_if.requester                mem_if,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] valid_vec;
    logic [XLEN-1:0]    addr_arr [NUM_REQ];
    mem_op_e            op_arr   [NUM_REQ];
    logic [XLEN-1:0]    data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] ful_vec;

    logic [IdxW-1:0] pick_start;
    logic [IdxW-1:0] win_idx;
    logic            any_valid;
    logic [IdxW-1:0] select;
    logic            fwd_en;

    function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
        int unsigned nxt;
        nxt = wrap_inc(int'(p), NUM_REQ);
        return nxt[IdxW-1:0];
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign valid_vec[i]              = req_if[i].req_valid;
        assign addr_arr[i]               = req_if[i].address;
        assign op_arr[i]                 = req_if[i].operation;
        assign data_arr[i]               = req_if[i].store_word;
        assign req_if[i].req_loaded_word = mem_if.req_loaded_word;
        assign req_if[i].req_fulfilled   = ful_vec[i];
    end

    assign pick_start = (ARB_MODE == ARB_FIXED_PRIORITY) ? '0 : rr_ptr_q;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .valid_i (valid_vec),
        .start_i (pick_start),
        .idx_o   (win_idx),
        .any_o   (any_valid)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        select   = win_idx;
        unique case (state_q)
            ST_IDLE: begin
                select = win_idx;
                if (any_valid) begin
                    owner_d = win_idx;
                    // Zero-latency memory: the grant completes in the same cycle.
                    if (mem_if.req_fulfilled) begin
                        rr_ptr_d = ptr_inc(win_idx);
                    end else begin
                        state_d = ST_GRANTED;
                    end
                end
            end
            ST_GRANTED: begin
                select = owner_q;
                if (mem_if.req_fulfilled) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ptr_inc(owner_q);
                end else if (!valid_vec[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = state_e'(1'bx);
                select  = 'x;
            end
        endcase
    end

    // Nothing is forwarded or acknowledged while reset is held.
    assign fwd_en = !reset && ((state_q == ST_GRANTED) || any_valid);

    always_comb begin
        ful_vec = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            ful_vec[i] = fwd_en && mem_if.req_fulfilled && (select == IdxW'(i));
        end
    end

    assign mem_if.req_valid  = fwd_en ? valid_vec[select] : 1'b0;
    assign mem_if.address    = fwd_en ? addr_arr[select]  : '0;
    assign mem_if.operation  = fwd_en ? op_arr[select]    : LOAD;
    assign mem_if.store_word = fwd_en ? data_arr[select]  : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign busy     = (state_q == ST_GRANTED);
    assign grant_id = owner_q;

    a_rr_ptr_range: assert property (@(posedge clk) disable iff (reset)
        int'(rr_ptr_q) < int'(NUM_REQ));

    a_ful_onehot: assert property (@(posedge clk) $onehot0(ful_vec));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench: 4-port round-robin, 3-port fixed-priority and 3-port round-robin arbiters.
module tb_mem_req_arbiter;
    import torrence_params::*;

    logic clk;
    logic reset;

    logic [3:0]  rv;
    logic [31:0] addr  [4];
    mem_op_e     op    [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata;
    logic        mem_ful_a, mem_ful_b, mem_ful_c;

    logic [3:0]  ful_a;
    logic [2:0]  ful_b, ful_c;
    logic [31:0] lw_a [4];
    logic [1:0]  a_gid, b_gid, c_gid;
    logic        a_busy, b_busy, c_busy;

    int n_checks;
    int n_fail;

    memory_if #(.XLEN(32)) a_req [4] ();
    memory_if #(.XLEN(32)) b_req [3] ();
    memory_if #(.XLEN(32)) c_req [3] ();
    memory_if #(.XLEN(32)) a_mem ();
    memory_if #(.XLEN(32)) b_mem ();
    memory_if #(.XLEN(32)) c_mem ();

    for (genvar g = 0; g < 4; g++) begin : g_a
        assign a_req[g].req_valid  = rv[g];
        assign a_req[g].address    = addr[g];
        assign a_req[g].operation  = op[g];
        assign a_req[g].store_word = wdata[g];
        assign ful_a[g]            = a_req[g].req_fulfilled;
        assign lw_a[g]             = a_req[g].req_loaded_word;
    end

    for (genvar g = 0; g < 3; g++) begin : g_bc
        assign b_req[g].req_valid  = rv[g];
        assign b_req[g].address    = addr[g];
        assign b_req[g].operation  = op[g];
        assign b_req[g].store_word = wdata[g];
        assign ful_b[g]            = b_req[g].req_fulfilled;
        assign c_req[g].req_valid  = rv[g];
        assign c_req[g].address    = addr[g];
        assign c_req[g].operation  = op[g];
        assign c_req[g].store_word = wdata[g];
        assign ful_c[g]            = c_req[g].req_fulfilled;
    end

    assign a_mem.req_fulfilled   = mem_ful_a;
    assign a_mem.req_loaded_word = rdata;
    assign b_mem.req_fulfilled   = mem_ful_b;
    assign b_mem.req_loaded_word = rdata;
    assign c_mem.req_fulfilled   = mem_ful_c;
    assign c_mem.req_loaded_word = rdata;

    mem_req_arbiter #(
        .XLEN     (32),
        .NUM_REQ  (4),
        .ARB_MODE (ARB_ROUND_ROBIN)
    ) dut_a (
        .clk      (clk),
        .reset    (reset),
        .req_if   (a_req),
        .mem_if   (a_mem),
        .grant_id (a_gid),
        .busy     (a_busy)
    );

    mem_req_arbiter #(
        .XLEN     (32),
        .NUM_REQ  (3),
        .ARB_MODE (ARB_FIXED_PRIORITY)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .req_if   (b_req),
        .mem_if   (b_mem),
        .grant_id (b_gid),
        .busy     (b_busy)
    );

    mem_req_arbiter #(
        .XLEN     (32),
        .NUM_REQ  (3),
        .ARB_MODE (ARB_ROUND_ROBIN)
    ) dut_c (
        .clk      (clk),
        .reset    (reset),
        .req_if   (c_req),
        .mem_if   (c_mem),
        .grant_id (c_gid),
        .busy     (c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        rv        = '0;
        mem_ful_a = 1'b0;
        mem_ful_b = 1'b0;
        mem_ful_c = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_i;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        mem_ful_a = 1'b0;
        mem_ful_b = 1'b0;
        mem_ful_c = 1'b0;
        rdata     = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i]  = 32'h1000_0000 + 32'(i) * 32'h10;
            op[i]    = LOAD;
            wdata[i] = 32'h5000_0000 + 32'(i);
        end
        rv = 4'b1111;

        // Reset state with every requester asserting valid.
        settle();
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_gid", 32'(a_gid), 32'd0);
        check_eq("rst_mem_valid", 32'(a_mem.req_valid), 32'd0);
        check_eq("rst_mem_addr", a_mem.address, 32'd0);
        cyc();
        reset = 1'b0;

        // Round-robin order 0,1,2,3,0 with memory fulfilling 2 cycles after each grant.
        for (int k = 0; k < 5; k++) begin
            exp_i = k % 4;
            settle();
            check_eq("rr_idle_busy", 32'(a_busy), 32'd0);
            check_eq("rr_grant_addr", a_mem.address, 32'h1000_0000 + 32'(exp_i) * 32'h10);
            cyc();
            settle();
            check_eq("rr_gid", 32'(a_gid), 32'(exp_i));
            cyc();
            mem_ful_a = 1'b1;
            rdata     = 32'hA5A5_0000 + 32'(k);
            settle();
            check_eq("rr_ful_onehot", 32'(ful_a), 32'(4'b0001 << exp_i));
            check_eq("rr_loaded_word", lw_a[exp_i], 32'hA5A5_0000 + 32'(k));
            cyc();
            mem_ful_a = 1'b0;
        end

        // Owner 1 withdraws before fulfilment while req 3 waits.
        apply_reset();
        rv = 4'b1010;
        settle();
        check_eq("ab_grant_addr", a_mem.address, 32'h1000_0010);
        cyc();
        settle();
        check_eq("ab_gid", 32'(a_gid), 32'd1);
        cyc();
        rv = 4'b1000;
        settle();
        check_eq("ab_drop_valid", 32'(a_mem.req_valid), 32'd0);
        check_eq("ab_no_pulse", 32'(ful_a), 32'd0);
        cyc();
        settle();
        check_eq("ab_idle", 32'(a_busy), 32'd0);
        check_eq("ab_rr_ptr", 32'(dut_a.rr_ptr_q), 32'd0);
        check_eq("ab_next_addr", a_mem.address, 32'h1000_0030);
        cyc();
        settle();
        check_eq("ab_next_gid", 32'(a_gid), 32'd3);

        // Zero-latency store fulfilled in the grant cycle.
        apply_reset();
        addr[2]   = 32'h0000_1000;
        op[2]     = STORE;
        wdata[2]  = 32'hDEAD_BEEF;
        rv        = 4'b0100;
        mem_ful_a = 1'b1;
        settle();
        check_eq("zl_valid", 32'(a_mem.req_valid), 32'd1);
        check_eq("zl_addr", a_mem.address, 32'h0000_1000);
        check_eq("zl_op", 32'(a_mem.operation), 32'd1);
        check_eq("zl_data", a_mem.store_word, 32'hDEAD_BEEF);
        check_eq("zl_ful", 32'(ful_a), 32'b0100);
        cyc();
        rv        = 4'b1001;
        mem_ful_a = 1'b0;
        settle();
        check_eq("zl_stay_idle", 32'(a_busy), 32'd0);
        check_eq("zl_pulse_len", 32'(ful_a), 32'd0);
        check_eq("zl_rr_adv_addr", a_mem.address, 32'h1000_0030);

        // Asynchronous reset in the middle of a grant.
        apply_reset();
        rv = 4'b0001;
        settle();
        cyc();
        settle();
        check_eq("ar_busy_before", 32'(a_busy), 32'd1);
        #2;
        reset     = 1'b1;
        mem_ful_a = 1'b1;
        #1;
        check_eq("ar_busy", 32'(a_busy), 32'd0);
        check_eq("ar_mem_valid", 32'(a_mem.req_valid), 32'd0);
        check_eq("ar_no_pulse", 32'(ful_a), 32'd0);
        cyc();
        cyc();
        rv        = 4'b1111;
        mem_ful_a = 1'b0;
        reset     = 1'b0;
        settle();
        check_eq("ar_first_addr", a_mem.address, 32'h1000_0000);
        cyc();
        settle();
        check_eq("ar_first_gid", 32'(a_gid), 32'd0);

        // Fixed priority: req 0 beats req 2, and keeps winning while it stays valid.
        apply_reset();
        rv = 4'b0101;
        settle();
        check_eq("fx_grant_addr", b_mem.address, 32'h1000_0000);
        cyc();
        settle();
        check_eq("fx_gid0", 32'(b_gid), 32'd0);
        cyc();
        mem_ful_b = 1'b1;
        settle();
        check_eq("fx_ful0", 32'(ful_b), 32'b001);
        cyc();
        mem_ful_b = 1'b0;
        settle();
        check_eq("fx_bubble", 32'(b_busy), 32'd0);
        check_eq("fx_regrant0", b_mem.address, 32'h1000_0000);
        cyc();
        settle();
        check_eq("fx_gid0_again", 32'(b_gid), 32'd0);
        cyc();
        mem_ful_b = 1'b1;
        settle();
        check_eq("fx_ful0_again", 32'(ful_b), 32'b001);
        cyc();
        mem_ful_b = 1'b0;
        rv        = 4'b0100;
        settle();
        check_eq("fx_req2_valid", 32'(b_mem.req_valid), 32'd1);
        check_eq("fx_req2_addr", b_mem.address, 32'h0000_1000);
        cyc();
        settle();
        check_eq("fx_gid2", 32'(b_gid), 32'd2);

        // Three-port round-robin with zero-latency memory: pointer wraps 2 -> 0.
        apply_reset();
        rv        = 4'b0111;
        mem_ful_c = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            if (k == 3) begin
                check_eq("c_rr_wrap", 32'(dut_c.rr_ptr_q), 32'd0);
            end
            check_eq("c_ful_seq", 32'(ful_c), 32'(3'b001 << (k % 3)));
            check_eq("c_idle", 32'(c_busy), 32'd0);
            cyc();
        end
        mem_ful_c = 1'b0;
        rv        = '0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter XLEN, default 32: address and data word width of every memory_if.
REQ-002 Parameter NUM_REQ, default 2, legal 2..8: number of upstream requester ports.
REQ-003 Parameter ARB_MODE, default ARB_ROUND_ROBIN: ARB_ROUND_ROBIN or ARB_FIXED_PRIORITY, where index 0 is highest priority.
REQ-004 Port clk, input, 1: single clock; all state updates on posedge.
REQ-005 Port reset, input, 1: reset is asynchronous and active-high.
REQ-006 Port req_if[NUM_REQ], memory_if.server: upstream requesters, such as L1 I/D caches and page walker.
REQ-007 Port mem_if, memory_if.requester: single downstream port toward L2 or memory.
REQ-008 Port grant_id, output, $clog2(NUM_REQ): index of the current owner; valid only while busy=1.
REQ-009 Port busy, output, 1: high while the arbiter is in ST_GRANTED.

Function
REQ-010 FSM has two states: ST_IDLE=1'b0 and ST_GRANTED=1'b1; an unknown state drives X on next_state and select.
REQ-011 ST_IDLE, no req_valid: mem_if.req_valid=0; address, store_word and operation=LOAD driven '0; stay in ST_IDLE.
REQ-012 ST_IDLE, any req_valid: winner selected combinationally in the same cycle; winner's fields forwarded to mem_if in that cycle (zero-cycle latency); owner register <= winner; go to ST_GRANTED.
REQ-013 ARB_ROUND_ROBIN: winner is the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-014 ARB_FIXED_PRIORITY: winner is the lowest valid index; rr_ptr is unused.
REQ-015 ST_GRANTED: select = owner; owner's address, operation, store_word and req_valid are forwarded unchanged; other requesters are ignored.
REQ-016 Ownership is held until mem_if.req_fulfilled=1 or the owner drops req_valid, whichever occurs first; then next state is ST_IDLE.
REQ-017 On fulfilled, rr_ptr <= owner+1, wrapping NUM_REQ-1 -> 0 for any NUM_REQ (not only powers of two).
REQ-018 On abort (owner drops valid without fulfilled), rr_ptr is unchanged and no fulfilled pulse is issued.
REQ-019 mem_if.req_loaded_word is broadcast to all req_if; req_if[i].req_fulfilled = mem_if.req_fulfilled & (select==i) & (state or winner valid).
REQ-020 Fulfilled in the same cycle a new request arrives elsewhere: return to ST_IDLE first; re-arbitration happens in the next cycle, giving exactly one bubble cycle.
REQ-021 Fulfilled in the ST_IDLE grant cycle (zero-latency memory): the pulse is routed to the winner, the FSM stays in ST_IDLE, and rr_ptr advances.
REQ-022 A requester that holds req_valid high is granted within NUM_REQ grants in round-robin mode (no starvation).

Reset
REQ-023 Asserting reset asynchronously forces state=ST_IDLE, owner=0 and rr_ptr=0; grant_id=0, busy=0 and mem_if.req_valid follows REQ-011.
REQ-024 Reset mid-transaction abandons the transaction; no req_fulfilled is propagated upstream while reset is high.

Structure
REQ-025 arb_mode_e (ARB_ROUND_ROBIN, ARB_FIXED_PRIORITY) lives in torrence_params next to LOAD/STORE; the FSM state enum is local to the module.
REQ-026 One sub-module, rr_pick #(N): purely combinational; inputs are the valid vector and the start pointer; outputs are the winner index and any_valid. It is reused for both modes, with start=0 for fixed priority.

Verification
REQ-027 NUM_REQ=4 RR: all 4 valid continuously, memory fulfils 2 cycles after each grant -> grant order 0,1,2,3,0; each fulfilled pulse reaches only its owner.
REQ-028 FIXED mode: req 2 and req 0 valid together -> req 0 is granted; after it is fulfilled and deasserted, req 2 is granted one cycle later.
REQ-029 Owner 1 drops valid before fulfilled with req 3 waiting -> FSM returns to ST_IDLE, rr_ptr is unchanged, req 3 is granted next, and no pulse reaches req 1.
REQ-030 Zero-latency fulfil in the grant cycle (address 0x0000_1000, STORE, data 0xDEAD_BEEF) -> mem_if sees exactly these values that cycle and the winner gets a one-cycle fulfilled pulse.
REQ-031 Reset asserted mid-grant, between clock edges -> busy=0 and mem_if.req_valid=0 immediately; after release, req 0 wins first.
REQ-032 NUM_REQ=3, fulfilled with owner=2 -> rr_ptr wraps to 0; an assertion checks rr_ptr < NUM_REQ and a $onehot0 on the fulfilled vector every cycle.
